mem_responder: RTL and testbench

Byte-serial memory/IO responder: the target end of the single-byte bus driven by the CPU's memory controller (address, write strobe, write byte in; read byte and UART back-pressure out). It holds the byte-addressable RAM, decodes the IO window, buffers outgoing UART bytes in a TX FIFO and raises `io_buffer_full` early enough that in-flight writes are never lost. It sits between the core's memory controller and the board-level RAM and UART.

---
 rtl/mem_responder.sv | 152 +++++++++++++++
 tb/tb_mem_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Byte-serial memory/IO responder: byte RAM, IO window at 0x30000, UART TX FIFO with early back-pressure.
// Optional RX FIFO on the IO data register is built when MEM_RESP_RX_EN is defined.
`timescale 1ns/1ps
module mem_responder #(
    parameter int unsigned ADDR_WIDTH = 18,
    parameter int unsigned TX_DEPTH   = 8,
    parameter int unsigned RX_DEPTH   = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid
);
    localparam int unsigned TxPtrW = $clog2(TX_DEPTH);
    localparam int unsigned TxCntW = TxPtrW + 1;
    localparam logic [17:0] IoData = 18'h30000;
    localparam logic [17:0] IoStat = 18'h30004;

    logic        is_io, bus_rd, bus_wr, data_sel, stat_sel;
    logic [17:0] io_off;
    logic        rx_nonempty;
    logic [7:0]  rx_head;
    logic [7:0]  rd_data;
    logic [7:0]  mem_din_q;
    logic        unused_addr;

    assign io_off      = mem_a[17:0];
    assign is_io       = (mem_a[17:16] == 2'b11);
    assign bus_rd      = rdy_in & ~mem_wr;
    assign bus_wr      = rdy_in & mem_wr;
    assign data_sel    = is_io & (io_off == IoData);
    assign stat_sel    = is_io & (io_off == IoStat);
    assign unused_addr = ^mem_a[31:18];

    // RAM contents survive reset, so no reset branch here.
    logic [7:0] ram_q [1 << ADDR_WIDTH];
    always_ff @(posedge clk_in) begin
        if (bus_wr && !is_io) ram_q[mem_a[ADDR_WIDTH-1:0]] <= mem_dout;
    end

    logic [7:0]        tx_mem_q [TX_DEPTH];
    logic [TxPtrW-1:0] tx_wr_q, tx_rd_q;
    logic [TxCntW-1:0] tx_cnt_q, tx_cnt_d;
    logic              tx_full, tx_push_req, tx_push, tx_pop;
    logic              tx_ovf_q, tx_ovf_d, ibf_q;

    assign tx_valid    = (tx_cnt_q != '0);
    assign tx_data     = tx_valid ? tx_mem_q[tx_rd_q] : 8'h00;
    assign tx_full     = (tx_cnt_q == TxCntW'(TX_DEPTH));
    assign tx_pop      = tx_valid & tx_ready;
    assign tx_push_req = bus_wr & data_sel;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign tx_push     = tx_push_req & (~tx_full | tx_pop);

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + TxCntW'(1);
        if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - TxCntW'(1);
        tx_ovf_d = tx_ovf_q;
        if (bus_rd && stat_sel)       tx_ovf_d = 1'b0;
        if (tx_push_req && !tx_push)  tx_ovf_d = 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
            tx_ovf_q <= 1'b0;
            ibf_q    <= 1'b0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + TxPtrW'(1);
            if (tx_pop)  tx_rd_q <= tx_rd_q + TxPtrW'(1);
            tx_cnt_q <= tx_cnt_d;
            tx_ovf_q <= tx_ovf_d;
            // Two slots of headroom cover writes already issued before the flag is seen.
            ibf_q    <= (tx_cnt_d >= TxCntW'(TX_DEPTH - 2));
        end
    end

    always_ff @(posedge clk_in) begin
        if (tx_push) tx_mem_q[tx_wr_q] <= mem_dout;
    end

    assign io_buffer_full = ibf_q;

`ifdef MEM_RESP_RX_EN
    localparam int unsigned RxPtrW = $clog2(RX_DEPTH);
    localparam int unsigned RxCntW = RxPtrW + 1;

    logic [7:0]        rx_mem_q [RX_DEPTH];
    logic [RxPtrW-1:0] rx_wr_q, rx_rd_q;
    logic [RxCntW-1:0] rx_cnt_q, rx_cnt_d;
    logic              rx_push, rx_pop;

    assign rx_nonempty = (rx_cnt_q != '0);
    assign rx_head     = rx_mem_q[rx_rd_q];
    assign rx_pop      = bus_rd & data_sel & rx_nonempty;
    assign rx_push     = rx_valid & ((rx_cnt_q != RxCntW'(RX_DEPTH)) | rx_pop);

    always_comb begin
        rx_cnt_d = rx_cnt_q;
        if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + RxCntW'(1);
        if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - RxCntW'(1);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (rx_push) rx_wr_q <= rx_wr_q + RxPtrW'(1);
            if (rx_pop)  rx_rd_q <= rx_rd_q + RxPtrW'(1);
            rx_cnt_q <= rx_cnt_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rx_push) rx_mem_q[rx_wr_q] <= rx_data;
    end
`else
    localparam int unsigned unused_rx_depth = RX_DEPTH;
    logic unused_rx;
    assign unused_rx   = ^{rx_data, rx_valid};
    assign rx_nonempty = 1'b0;
    assign rx_head     = 8'h00;
`endif

    always_comb begin
        rd_data = 8'h00;
        if (!is_io)        rd_data = ram_q[mem_a[ADDR_WIDTH-1:0]];
        else if (data_sel) rd_data = rx_nonempty ? rx_head : 8'h00;
        else if (stat_sel) rd_data = {5'b0, tx_ovf_q, rx_nonempty, tx_full};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)      mem_din_q <= 8'h00;
        else if (bus_rd) mem_din_q <= rd_data;
    end

    assign mem_din = mem_din_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: queue-based reference model checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_mem_responder;
    localparam int TXD = 8;
    localparam int RXD = 8;

    logic        clk, rst_in, rdy_in, mem_wr, tx_ready, rx_valid;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout, mem_din, tx_data, rx_data;
    logic        io_buffer_full, tx_valid;

    mem_responder dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a), .mem_wr(mem_wr),
        .mem_dout(mem_dout), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;

    // Reference model state
    logic [7:0] ram [int];
    logic [7:0] tx_q [$];
    logic [7:0] rx_q [$];
    logic [7:0] exp_din = 8'h00;
    bit         din_known = 0;
    bit         ovf = 0;
    bit         exp_ibf = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int         off;
        bit         io;
        bit         rx_ne;
        logic [7:0] stat;
        logic [7:0] junk;
        off = int'(mem_a[17:0]);
        io  = (mem_a[17:16] == 2'b11);
        if (rst_in) begin
            tx_q.delete();
            rx_q.delete();
            exp_din = 8'h00;
            din_known = 1;
            ovf = 0;
            exp_ibf = 0;
            return;
        end
`ifdef MEM_RESP_RX_EN
        rx_ne = (rx_q.size() != 0);
`else
        rx_ne = 0;
`endif
        stat = {5'b0, ovf, rx_ne, (tx_q.size() == TXD)};
        if (tx_q.size() != 0 && tx_ready) junk = tx_q.pop_front();
        if (rdy_in) begin
            if (mem_wr) begin
                if (!io) ram[off] = mem_dout;
                else if (off == 'h30000) begin
                    if (tx_q.size() < TXD) tx_q.push_back(mem_dout);
                    else ovf = 1;
                end
            end else begin
                din_known = 1;
                exp_din = 8'h00;
                if (!io) begin
                    if (ram.exists(off)) exp_din = ram[off];
                    else din_known = 0;
                end else if (off == 'h30000) begin
`ifdef MEM_RESP_RX_EN
                    if (rx_q.size() != 0) exp_din = rx_q.pop_front();
`endif
                end else if (off == 'h30004) begin
                    exp_din = stat;
                    ovf = 0;
                end
            end
        end
`ifdef MEM_RESP_RX_EN
        if (rx_valid && rx_q.size() < RXD) rx_q.push_back(rx_data);
`endif
        exp_ibf = (tx_q.size() >= TXD - 2);
    endtask

    task automatic compare();
        logic [7:0] head;
        head = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
        if (din_known) chk("model mem_din", mem_din, exp_din);
        chk("model io_buffer_full", {7'b0, io_buffer_full}, {7'b0, exp_ibf});
        chk("model tx_valid", {7'b0, tx_valid}, {7'b0, (tx_q.size() != 0)});
        chk("model tx_data", tx_data, head);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) compare();
    end

    // Drive one bus cycle; returns 1 time unit after the edge that consumed it.
    task automatic cyc(input logic rdy, input logic wr, input logic [31:0] a, input logic [7:0] d);
        rdy_in = rdy;
        mem_wr = wr;
        mem_a = a;
        mem_dout = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b1, 1'b1, 32'h0003_FFF0, 8'h00);
    endtask

    initial begin
        rst_in = 1; rdy_in = 1; mem_wr = 1; mem_a = 32'h0003_FFF0; mem_dout = 0;
        tx_ready = 0; rx_valid = 0; rx_data = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_in = 0;
        chk_en = 1;
        chk("reset mem_din", mem_din, 8'h00);
        chk("reset tx_valid", {7'b0, tx_valid}, 8'h00);
        chk("reset io_buffer_full", {7'b0, io_buffer_full}, 8'h00);

        // RAM round trip and read-after-write
        cyc(1, 1, 32'h0000_0010, 8'hA5);
        cyc(1, 1, 32'h0000_0011, 8'h5A);
        cyc(1, 0, 32'h0000_0010, 8'h00);
        chk("ram rd 0x10", mem_din, 8'hA5);
        cyc(1, 0, 32'h0000_0011, 8'h00);
        chk("ram rd 0x11", mem_din, 8'h5A);
        cyc(1, 1, 32'h0000_0012, 8'h3C);
        cyc(1, 0, 32'h0000_0012, 8'h00);
        chk("raw 0x12", mem_din, 8'h3C);
        cyc(1, 0, 32'hFFFC_0010, 8'h00);
        chk("upper addr bits ignored", mem_din, 8'hA5);

        // TX back-pressure
        for (int i = 0; i < 6; i++) begin
            cyc(1, 1, 32'h0003_0000, 8'(8'h41 + i));
            if (i == 4) chk("ibf low at count 5", {7'b0, io_buffer_full}, 8'h00);
        end
        chk("ibf high at count 6", {7'b0, io_buffer_full}, 8'h01);
        cyc(1, 1, 32'h0003_0000, 8'h47);
        cyc(1, 1, 32'h0003_0000, 8'h48);
        cyc(1, 1, 32'h0003_0000, 8'h49);
        cyc(1, 0, 32'h0003_0004, 8'h00);
        chk("status ovf+full", mem_din, 8'h05);
        cyc(1, 0, 32'h0003_0004, 8'h00);
        chk("status ovf cleared", mem_din, 8'h01);
        cyc(1, 0, 32'h0003_0008, 8'h00);
        chk("other io read", mem_din, 8'h00);

        // TX drain
        tx_ready = 1;
        for (int i = 0; i < 8; i++) begin
            chk("drain tx_data", tx_data, 8'(8'h41 + i));
            if (i == 2) chk("ibf at count 6", {7'b0, io_buffer_full}, 8'h01);
            if (i == 3) chk("ibf at count 5", {7'b0, io_buffer_full}, 8'h00);
            idle();
        end
        chk("drain tx_valid low", {7'b0, tx_valid}, 8'h00);

        // rdy_in pause
        cyc(1, 1, 32'h0000_0020, 8'h11);
        cyc(1, 0, 32'h0000_0010, 8'h00);
        cyc(0, 1, 32'h0000_0020, 8'h77);
        chk("pause hold 1", mem_din, 8'hA5);
        cyc(0, 0, 32'h0000_0020, 8'h00);
        chk("pause hold 2", mem_din, 8'hA5);
        cyc(0, 1, 32'h0003_0000, 8'h99);
        chk("pause no tx push", {7'b0, tx_valid}, 8'h00);
        cyc(1, 0, 32'h0000_0020, 8'h00);
        chk("pause no ram write", mem_din, 8'h11);
        cyc(1, 1, 32'h0003_0000, 8'hEE);
        chk("write holds mem_din", mem_din, 8'h11);
        idle();

        // RX path
        rx_valid = 1; rx_data = 8'h31;
        idle();
        rx_data = 8'h32;
        idle();
        rx_valid = 0;
        cyc(1, 0, 32'h0003_0004, 8'h00);
`ifdef MEM_RESP_RX_EN
        chk("rx status", mem_din, 8'h02);
        cyc(1, 0, 32'h0003_0000, 8'h00);
        chk("rx pop 1", mem_din, 8'h31);
        cyc(1, 0, 32'h0003_0000, 8'h00);
        chk("rx pop 2", mem_din, 8'h32);
`else
        chk("rx status", mem_din, 8'h00);
        cyc(1, 0, 32'h0003_0000, 8'h00);
        chk("rx pop 1", mem_din, 8'h00);
        cyc(1, 0, 32'h0003_0000, 8'h00);
        chk("rx pop 2", mem_din, 8'h00);
`endif
        cyc(1, 0, 32'h0003_0000, 8'h00);
        chk("rx empty", mem_din, 8'h00);

        // Reset mid-stream
        tx_ready = 0;
        cyc(1, 1, 32'h0003_0000, 8'h61);
        cyc(1, 1, 32'h0003_0000, 8'h62);
        cyc(1, 1, 32'h0003_0000, 8'h63);
        cyc(1, 0, 32'h0000_0010, 8'h00);
        rst_in = 1;
        cyc(1, 0, 32'h0000_0011, 8'h00);
        rst_in = 0;
        chk("rst mem_din", mem_din, 8'h00);
        chk("rst tx_valid", {7'b0, tx_valid}, 8'h00);
        chk("rst ibf", {7'b0, io_buffer_full}, 8'h00);
        cyc(1, 0, 32'h0000_0010, 8'h00);
        chk("ram survives reset", mem_din, 8'hA5);

        // Push into a full FIFO while it pops
        for (int i = 0; i < 8; i++) cyc(1, 1, 32'h0003_0000, 8'(8'h50 + i));
        tx_ready = 1;
        cyc(1, 1, 32'h0003_0000, 8'h58);
        for (int i = 0; i < 8; i++) begin
            chk("full push+pop order", tx_data, 8'(8'h51 + i));
            idle();
        end
        chk("full push+pop empty", {7'b0, tx_valid}, 8'h00);
        cyc(1, 0, 32'h0003_0004, 8'h00);
        chk("no overflow on push+pop", mem_din, 8'h00);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
